// File: rtl/uart_tcp_pkg.sv
// Shared types for the UART transmit path: arbiter FSM states, default
// header tag, command descriptor and the round-robin grant helper.
package uart_tcp_pkg;

    localparam int NUM_SRC = 3;

    // Tag byte placed in front of packets from source 0; source i uses base+i.
    localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_FWD   = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    // Descriptor handed between the TCP command layer and the UART framer.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] length;
        logic [1:0]  source;
    } tcp_command_info;

    // Round-robin pick: the first valid source in the order
    // last+1, last+2, last+3 (mod 3). Returns last if nothing is valid.
    function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                           input logic [NUM_SRC-1:0] valid);
        logic [1:0] pick;
        int         idx;
        pick = last;
        // Walk the candidates from lowest to highest priority so the
        // highest-priority valid source is the one left in pick.
        for (int i = NUM_SRC; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_SRC;
            if (valid[idx]) pick = 2'(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Stream bundle between the three packet sources, the arbiter and the UART.
//
// Handshake: every stream uses AXI-Stream style valid/ready. A beat transfers
// on a rising clk edge where valid and ready are both high. Once valid is
// raised the sender keeps data/last stable until the transfer; ready may be
// driven combinationally and may change at any time.
interface uart_tx_arbiter_if
    import uart_tcp_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    logic [NUM_SRC*DATA_WIDTH-1:0] src_tdata;
    logic [NUM_SRC-1:0]            src_tvalid;
    logic [NUM_SRC-1:0]            src_tready;
    logic [NUM_SRC-1:0]            src_tlast;
    logic [DATA_WIDTH-1:0]         uart_out_tdata;
    logic                          uart_out_tvalid;
    logic                          uart_out_tready;
    logic                          uart_out_tlast;

    // Arbiter side: sinks the sources, drives the UART byte stream.
    modport master (
        input  src_tdata, src_tvalid, src_tlast, uart_out_tready,
        output src_tready, uart_out_tdata, uart_out_tvalid, uart_out_tlast
    );

    // Environment side: drives the sources, sinks the UART byte stream.
    modport slave (
        output src_tdata, src_tvalid, src_tlast, uart_out_tready,
        input  src_tready, uart_out_tdata, uart_out_tvalid, uart_out_tlast
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter merging three byte streams onto one UART.
// Each granted packet is prefixed with a per-source tag byte and truncated
// (with the remainder drained) once it reaches MAX_LEN payload bytes.
module uart_tx_arbiter
    import uart_tcp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    MAX_LEN    = 1500,
    parameter logic [DATA_WIDTH-1:0] TAG_BASE   = DATA_WIDTH'(TAG_BASE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.master bus,
    output logic              busy,
    output logic              overlong,
    output arb_state_e        fsm_state
);

    localparam int CW = $clog2(MAX_LEN + 1);

    arb_state_e            state;
    logic [1:0]            grant;
    logic [1:0]            last_grant;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_last;
    logic                  slot_free;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic [NUM_SRC-1:0]    ready;

    // The output register can take a new byte when empty or being emptied.
    assign slot_free = !out_valid || bus.uart_out_tready;

    // Steer the granted source's stream to the FSM.
    always_comb begin
        sel_data  = bus.src_tdata[0 +: DATA_WIDTH];
        sel_valid = bus.src_tvalid[0];
        sel_last  = bus.src_tlast[0];
        case (grant)
            2'd1: begin
                sel_data  = bus.src_tdata[DATA_WIDTH +: DATA_WIDTH];
                sel_valid = bus.src_tvalid[1];
                sel_last  = bus.src_tlast[1];
            end
            2'd2: begin
                sel_data  = bus.src_tdata[2*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = bus.src_tvalid[2];
                sel_last  = bus.src_tlast[2];
            end
            default: ;
        endcase
    end

    // Only the granted source is ever ready; while draining it is always ready.
    always_comb begin
        ready = '0;
        case (state)
            ST_FWD:   ready[grant] = slot_free;
            ST_DRAIN: ready[grant] = 1'b1;
            default:  ;
        endcase
    end

    // Arbitration FSM together with the single output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd2;
            cnt        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            overlong   <= 1'b0;
        end else begin
            overlong <= 1'b0;
            if (out_valid && bus.uart_out_tready) out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|bus.src_tvalid) begin
                        grant <= rr_pick(last_grant, bus.src_tvalid);
                        state <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (slot_free) begin
                        out_data  <= TAG_BASE + DATA_WIDTH'(grant);
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    if (sel_valid && slot_free) begin
                        out_data  <= sel_data;
                        out_last  <= sel_last;
                        out_valid <= 1'b1;
                        cnt       <= cnt + 1'b1;
                        if (sel_last) begin
                            last_grant <= grant;
                            state      <= ST_IDLE;
                        end else if (cnt == CW'(MAX_LEN - 1)) begin
                            // Byte MAX_LEN closes the frame; the rest is dropped.
                            out_last <= 1'b1;
                            overlong <= 1'b1;
                            state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sel_valid && sel_last) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.src_tready      = ready;
    assign bus.uart_out_tdata  = out_data;
    assign bus.uart_out_tvalid = out_valid;
    assign bus.uart_out_tlast  = out_last;
    assign busy                = (state != ST_IDLE);
    assign fsm_state           = state;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: byte width of every stream.
REQ-002 Parameter MAX_LEN, default 1500: maximum payload bytes forwarded per packet.
REQ-003 Parameter TAG_BASE, default 8'hA0: header tag for source 0; source i uses TAG_BASE+i.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 src_tdata  input  3*DATA_WIDTH  packed source data; [0]=app_response, [1]=eth_phy, [2]=rest_of_frame.
REQ-007 src_tvalid  input  3  per-source valid.
REQ-008 src_tready  output  3  per-source ready.
REQ-009 src_tlast  input  3  per-source end of packet.
REQ-010 uart_out_tdata  output  DATA_WIDTH  byte to physical UART.
REQ-011 uart_out_tvalid  output  1  output valid.
REQ-012 uart_out_tready  input  1  UART accepts byte.
REQ-013 uart_out_tlast  output  1  last byte of framed packet.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 overlong  output  1  one-cycle pulse when a packet is truncated at MAX_LEN.

Function
REQ-016 FSM states IDLE, HDR, FWD, DRAIN; grants are packet-atomic: no switch between sources before tlast or truncation.
REQ-017 Output is a single registered stage: "slot free" = !uart_out_tvalid || uart_out_tready; data/last held stable while tvalid && !tready.
REQ-018 IDLE: if any src_tvalid, grant = first valid source in round-robin order last_grant+1, +2, +3 (mod 3); latch grant; go to HDR; src_tready all 0.
REQ-019 HDR: when slot free, load uart_out_tdata = TAG_BASE+grant, tlast=0, tvalid=1; clear byte counter; go to FWD.
REQ-020 FWD: src_tready[grant] = slot free; other readies 0; on handshake load byte and src tlast into output register, counter+1.
REQ-021 FWD, accepted byte has tlast: last_grant <= grant; go to IDLE.
REQ-022 FWD, accepted byte is byte number MAX_LEN without tlast: force uart_out_tlast=1, pulse overlong, go to DRAIN.
REQ-023 DRAIN: src_tready[grant]=1; bytes discarded, output register untouched; on accepted tlast set last_grant <= grant, go to IDLE.
REQ-024 Throughput: one payload byte per cycle in FWD when uart_out_tready held high; per-packet overhead exactly one header byte plus one IDLE cycle.
REQ-025 Counter width $clog2(MAX_LEN+1); no wrap; single-byte packet (tlast on first byte) produces header + 1 byte, tlast on that byte.
REQ-026 Source whose tvalid drops mid-packet keeps the grant; arbiter waits, no timeout.
REQ-027 IDLE may be entered while the last output byte is still pending; next HDR waits for slot free.

Reset
REQ-028 While rst_n low: state=IDLE, last_grant=2 (source 0 first priority), counter=0, uart_out_tvalid=0, uart_out_tdata=0, uart_out_tlast=0, src_tready=0, busy=0, overlong=0.
REQ-029 Reset mid-packet discards the partial packet with no tlast emitted; operation resumes from IDLE after deassertion.

Structure
REQ-030 State enum and TAG_BASE default constant live in the shared uart_tcp_pkg alongside tcp_command_info.
REQ-031 Single module; round-robin selection may be a function in the package; no sub-module.

Verification
REQ-032 Source 1 sends 3 bytes 11,22,33 (tlast on 33), tready=1 -> output A1,11,22,33 on consecutive cycles, tlast only on 33.
REQ-033 All three sources valid from reset, one 2-byte packet each -> order A0.., A1.., A2..; then source 0 again first.
REQ-034 Source 0 packet of 4 bytes, uart_out_tready toggling 1/0 -> 5 bytes out in order, tdata stable while stalled, no loss.
REQ-035 MAX_LEN=4, source 2 sends 7 bytes -> output A2 + first 4 bytes, tlast on 4th, overlong pulses once, bytes 5-7 drained, busy low after byte 7.
REQ-036 rst_n low for 1 cycle after 2 of 5 bytes of source 0 -> tvalid 0 immediately; new source-1 packet then framed with A1.
REQ-037 Single-byte packet 5A on source 0 -> output A0, 5A with tlast on 5A.
